word_assembler: RTL and testbench
=================================

WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 Parameter: MSBFirst, default 1; 1 = first byte of a pair is Word_o[15:8], 0 = first byte is Word_o[7:0].
REQ-002 Port: Clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: Reset_i  input  1  asynchronous, active-high reset; takes effect immediately, independent of Clk_i.
REQ-004 Port: Byte_i  input  8  incoming data byte; qualified by ByteValid_i.
REQ-005 Port: ByteValid_i  input  1  Byte_i is valid this cycle; one byte accepted per cycle in which it is high.
REQ-006 Port: Clear_i  input  1  synchronous abort; discards any partially assembled pair.
REQ-007 Port: Timeout_i  input  16  inter-byte timeout in clock cycles; 0 disables the timeout.
REQ-008 Port: Word_o  output  16  last completed word; held between completions.
REQ-009 Port: WordValid_o  output  1  one-cycle strobe marking a new Word_o; intended to drive a downstream word register enable.
REQ-010 Port: Pending_o  output  1  high while the first byte of a pair is held.
REQ-011 Port: Timeout_o  output  1  one-cycle strobe marking a discarded pair due to timeout.

Function
REQ-012 FSM states: IDLE (awaiting first byte) and HAVE_FIRST (first byte held); Pending_o SHALL equal (state == HAVE_FIRST).
REQ-013 IDLE, ByteValid_i=1, Clear_i=0: latch Byte_i into the first-byte register, load the 16-bit timer with Timeout_i, go to HAVE_FIRST.
REQ-014 HAVE_FIRST, ByteValid_i=1, Clear_i=0: update Word_o on that edge, with byte placement per MSBFirst; go to IDLE.
REQ-015 WordValid_o SHALL be registered and high for exactly the one cycle following the edge at which the second byte is sampled; latency is 1 cycle from second-byte edge to Word_o/WordValid_o.
REQ-016 Back-to-back bytes every cycle SHALL yield one word per two cycles, with no byte lost.
REQ-017 HAVE_FIRST, ByteValid_i=0, timer loaded non-zero: decrement the timer by 1 per cycle.
REQ-018 Timer expiry: at the edge where the timer decrements from 1 to 0, discard the first byte and go to IDLE; Timeout_o is high for the following cycle only; Word_o is unchanged.
REQ-019 A loaded value of 0 SHALL disable the timeout; HAVE_FIRST is held indefinitely.
REQ-020 Timeout_i SHALL be sampled only at the first-byte edge; later changes have no effect on the pair in progress.
REQ-021 Simultaneous second byte and timer expiry: the byte wins; the word completes; no Timeout_o.
REQ-022 Clear_i=1 has highest priority (below reset): go to IDLE, discard the held byte, ignore ByteValid_i that cycle; no WordValid_o or Timeout_o strobe results; Word_o is unchanged.
REQ-023 WordValid_o and Timeout_o SHALL never be high in the same cycle.
REQ-024 Word_o SHALL change only on a word completion.

Reset
REQ-025 While Reset_i=1: state=IDLE, Word_o=16'h0000, WordValid_o=0, Pending_o=0, Timeout_o=0, timer=0, first-byte register=8'h00.
REQ-026 Reset mid-pair SHALL discard the held byte.
REQ-027 The first byte accepted after reset release is treated as a first byte.
REQ-028 Reset asserted during a WordValid_o or Timeout_o strobe cycle SHALL force the strobe low immediately.

Verification
REQ-029 MSBFirst=1; bytes 8'hA5 then 8'h3C on consecutive cycles -> next cycle Word_o=16'hA53C, WordValid_o=1 for one cycle, Pending_o 1 for one cycle then 0.
REQ-030 MSBFirst=0; bytes 8'hA5, 8'h3C, 8'h12, 8'h34 continuous -> Word_o=16'h3CA5 then 16'h3412, two WordValid_o pulses two cycles apart.
REQ-031 Timeout_i=5; byte 8'h11, then idle -> 5 edges later state IDLE, Timeout_o=1 for one cycle, Word_o unchanged; next bytes 8'h22, 8'h33 -> Word_o=16'h2233 (MSBFirst=1).
REQ-032 Timeout_i=3; byte 8'h11, second byte 8'h77 on the third edge (expiry edge) -> Word_o=16'h1177, WordValid_o=1, Timeout_o stays 0.
REQ-033 Byte 8'h55, then Clear_i=1 with ByteValid_i=1 and Byte_i=8'h66 -> Pending_o=0, no strobes; following 8'h01, 8'h02 -> Word_o=16'h0102.
REQ-034 Byte 8'hFF accepted, Reset_i pulsed asynchronously mid-cycle -> all outputs 0 immediately; after release, 8'hAB, 8'hCD -> Word_o=16'hABCD.

Source files
------------

// File: rtl/word_assembler_if.sv
// Byte-in / word-out bus for word_assembler.
// slave is the assembler side; master is the byte source / word consumer side.
interface word_assembler_if;
  logic [7:0]  Byte_i;
  logic        ByteValid_i;
  logic        Clear_i;
  logic [15:0] Timeout_i;
  logic [15:0] Word_o;
  logic        WordValid_o;
  logic        Pending_o;
  logic        Timeout_o;

  modport slave (
    input  Byte_i, ByteValid_i, Clear_i, Timeout_i,
    output Word_o, WordValid_o, Pending_o, Timeout_o
  );

  modport master (
    output Byte_i, ByteValid_i, Clear_i, Timeout_i,
    input  Word_o, WordValid_o, Pending_o, Timeout_o
  );
endinterface

// File: rtl/word_assembler.sv
// Pairs consecutive accepted bytes into 16-bit words.
// A held first byte is dropped if the second does not arrive within the
// inter-byte timeout sampled with the first byte (0 = wait forever).
module word_assembler #(
  parameter bit MSBFirst = 1'b1
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  word_assembler_if.slave   bus
);

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  first_byte, first_byte_next;
  logic [15:0] timer, timer_next;
  logic [15:0] word, word_next;
  logic        word_valid, word_valid_next;
  logic        timed_out, timed_out_next;

  // State and output registers; reset clears every strobe immediately.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state      <= IDLE;
      first_byte <= '0;
      timer      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state      <= state_next;
      first_byte <= first_byte_next;
      timer      <= timer_next;
      word       <= word_next;
      word_valid <= word_valid_next;
      timed_out  <= timed_out_next;
    end
  end

  // Next-state logic: clear beats a byte, a second byte beats timer expiry.
  always_comb begin
    state_next      = state;
    first_byte_next = first_byte;
    timer_next      = timer;
    word_next       = word;
    word_valid_next = 1'b0;
    timed_out_next  = 1'b0;

    if (bus.Clear_i) begin
      state_next      = IDLE;
      first_byte_next = '0;
      timer_next      = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ByteValid_i) begin
            first_byte_next = bus.Byte_i;
            timer_next      = bus.Timeout_i;
            state_next      = HAVE_FIRST;
          end
        end
        HAVE_FIRST: begin
          if (bus.ByteValid_i) begin
            word_next       = MSBFirst ? {first_byte, bus.Byte_i}
                                       : {bus.Byte_i, first_byte};
            word_valid_next = 1'b1;
            timer_next      = '0;
            state_next      = IDLE;
          end else if (timer != '0) begin
            // A timer loaded with zero never counts, so the pair waits forever.
            timer_next = timer - 16'd1;
            if (timer == 16'd1) begin
              timed_out_next  = 1'b1;
              first_byte_next = '0;
              state_next      = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.Word_o      = word;
  assign bus.WordValid_o = word_valid;
  assign bus.Pending_o   = (state == HAVE_FIRST);
  assign bus.Timeout_o   = timed_out;

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: an MSB-first and an LSB-first instance share
// one stimulus stream; a cycle-indexed reference model predicts words,
// timeouts and pending status, and a negedge monitor checks them.
module tb_word_assembler;

  logic clk;
  logic rst;

  word_assembler_if bus_m ();
  word_assembler_if bus_l ();

  word_assembler #(.MSBFirst(1'b1)) u_msb (.Clk_i(clk), .Reset_i(rst), .bus(bus_m.slave));
  word_assembler #(.MSBFirst(1'b0)) u_lsb (.Clk_i(clk), .Reset_i(rst), .bus(bus_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         edge_no;
    bit         pend;
    logic [7:0] f;
    logic [7:0] s;
  } status_t;

  typedef struct {
    int         edge_no;
    bit         is_word;
  } event_t;

  status_t status_q[$];
  event_t  ev_q[$];

  // Reference model: pair held with an absolute expiry edge number.
  bit         m_have     = 1'b0;
  logic [7:0] m_held     = '0;
  int         m_deadline = 0;
  logic [7:0] m_f        = '0;
  logic [7:0] m_s        = '0;
  int         edge_n     = 0;
  int         mon_edge   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the effect of the coming edge k given the applied inputs.
  task automatic model(input int k, input bit v, input logic [7:0] b, input bit c, input logic [15:0] t);
    event_t ev;
    status_t st;
    if (rst) begin
      m_have = 1'b0; m_f = '0; m_s = '0; m_deadline = 0;
    end else if (c) begin
      m_have = 1'b0;
    end else if (!m_have) begin
      if (v) begin
        m_have     = 1'b1;
        m_held     = b;
        m_deadline = (t == 16'd0) ? 0 : k + int'(t);
      end
    end else if (v) begin
      m_f = m_held; m_s = b; m_have = 1'b0;
      ev.edge_no = k; ev.is_word = 1'b1;
      ev_q.push_back(ev);
    end else if (m_deadline != 0 && m_deadline == k) begin
      m_have = 1'b0;
      ev.edge_no = k; ev.is_word = 1'b0;
      ev_q.push_back(ev);
    end
    st.edge_no = k; st.pend = m_have; st.f = m_f; st.s = m_s;
    status_q.push_back(st);
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit c, input logic [15:0] t);
    bus_m.ByteValid_i = v; bus_m.Byte_i = b; bus_m.Clear_i = c; bus_m.Timeout_i = t;
    bus_l.ByteValid_i = v; bus_l.Byte_i = b; bus_l.Clear_i = c; bus_l.Timeout_i = t;
    model(edge_n + 1, v, b, c, t);
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Assert reset after this cycle's negedge check; outputs must clear at once.
  task automatic mid_reset();
    #6;
    rst = 1'b1;
    m_have = 1'b0; m_f = '0; m_s = '0; m_deadline = 0;
    #1;
    check("rst_word_m", bus_m.Word_o, 32'h0);
    check("rst_word_l", bus_l.Word_o, 32'h0);
    check("rst_wv_m",   bus_m.WordValid_o, 32'h0);
    check("rst_wv_l",   bus_l.WordValid_o, 32'h0);
    check("rst_to_m",   bus_m.Timeout_o, 32'h0);
    check("rst_to_l",   bus_l.Timeout_o, 32'h0);
    check("rst_pend_m", bus_m.Pending_o, 32'h0);
    check("rst_pend_l", bus_l.Pending_o, 32'h0);
    step(1'b1, 8'hEE, 1'b0, 16'd2);
    rst = 1'b0;
  endtask

  always @(posedge clk) mon_edge++;

  // Monitor: per-cycle status plus strobe events popped as the DUTs present them.
  always @(negedge clk) begin
    status_t st;
    event_t  ev;
    bit      exp_wv, exp_to;
    if (status_q.size() > 0) begin
      st = status_q.pop_front();
      check("edge_sync", mon_edge, st.edge_no);
      check("pending_m", bus_m.Pending_o, st.pend);
      check("pending_l", bus_l.Pending_o, st.pend);
      check("word_m", bus_m.Word_o, {st.f, st.s});
      check("word_l", bus_l.Word_o, {st.s, st.f});
      check("excl_m", bus_m.WordValid_o & bus_m.Timeout_o, 32'h0);
      exp_wv = 1'b0; exp_to = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].edge_no == mon_edge) begin
        ev = ev_q.pop_front();
        exp_wv = ev.is_word;
        exp_to = !ev.is_word;
      end
      check("word_valid_m", bus_m.WordValid_o, exp_wv);
      check("word_valid_l", bus_l.WordValid_o, exp_wv);
      check("timeout_m", bus_m.Timeout_o, exp_to);
      check("timeout_l", bus_l.Timeout_o, exp_to);
    end
  end

  initial begin
    rst = 1'b1;
    #1;
    check("init_word", bus_m.Word_o, 32'h0);
    check("init_pend", bus_m.Pending_o, 32'h0);
    step(1'b1, 8'h99, 1'b0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 16'd0);
    rst = 1'b0;

    // A5,3C,12,34 back to back: MSB -> A53C, 1234 ; LSB -> 3CA5, 3412
    step(1'b1, 8'hA5, 1'b0, 16'd0);
    step(1'b1, 8'h3C, 1'b0, 16'd0);
    step(1'b1, 8'h12, 1'b0, 16'd0);
    step(1'b1, 8'h34, 1'b0, 16'd0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 16'd0);

    // Timeout 5, later Timeout_i changes must not matter
    step(1'b1, 8'h11, 1'b0, 16'd5);
    repeat (6) step(1'b0, 8'h00, 1'b0, 16'hFFFF);
    step(1'b1, 8'h22, 1'b0, 16'd0);
    step(1'b1, 8'h33, 1'b0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 16'd0);

    // Second byte on the expiry edge wins
    step(1'b1, 8'h11, 1'b0, 16'd3);
    step(1'b0, 8'h00, 1'b0, 16'd1);
    step(1'b0, 8'h00, 1'b0, 16'd1);
    step(1'b1, 8'h77, 1'b0, 16'd1);
    step(1'b0, 8'h00, 1'b0, 16'd0);

    // Clear with a byte present discards both
    step(1'b1, 8'h55, 1'b0, 16'd0);
    step(1'b1, 8'h66, 1'b1, 16'd0);
    step(1'b1, 8'h01, 1'b0, 16'd0);
    step(1'b1, 8'h02, 1'b0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 16'd0);

    // Async reset mid-pair, then a fresh pair
    step(1'b1, 8'hFF, 1'b0, 16'd0);
    mid_reset();
    step(1'b1, 8'hAB, 1'b0, 16'd0);
    step(1'b1, 8'hCD, 1'b0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 16'd0);

    // Reset during a word strobe, then during a timeout strobe (timeout 1)
    step(1'b1, 8'h10, 1'b0, 16'd0);
    step(1'b1, 8'h20, 1'b0, 16'd0);
    mid_reset();
    step(1'b1, 8'h30, 1'b0, 16'd1);
    step(1'b0, 8'h00, 1'b0, 16'd0);
    mid_reset();

    // Timeout 0 holds indefinitely
    step(1'b1, 8'h09, 1'b0, 16'd0);
    repeat (40) step(1'b0, 8'h00, 1'b0, 16'd1);
    step(1'b1, 8'h08, 1'b0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 16'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          v, c;
      logic [7:0]  b;
      logic [15:0] t;
      int unsigned r;
      v = ($urandom_range(0, 99) < 55);
      c = ($urandom_range(0, 99) < 4);
      b = 8'($urandom());
      r = $urandom_range(0, 9);
      t = (r < 2) ? 16'd0 : (r < 4) ? 16'd1 : 16'($urandom_range(2, 6));
      if ($urandom_range(0, 199) == 0) mid_reset();
      else step(v, b, c, t);
    end

    repeat (3) step(1'b0, 8'h00, 1'b0, 16'd0);
    #20;
    check("status_drained", status_q.size(), 32'h0);
    check("events_drained", ev_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
